// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage of the multicycle core.
// Issues one word read on the imem req/gnt/rvalid bus per start pulse, buffers
// the returned word for the instruction register and reports misaligned PCs,
// bus errors and (with FETCH_TIMEOUT_EN defined) hung transactions as faults.

package riscv_pkg;
    parameter int XLEN = 32;
endpackage

module instr_fetch_unit #(
    parameter int XLEN           = riscv_pkg::XLEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            fetch_start_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    output logic [XLEN-1:0] ir_data_o,
    output logic            ir_wr_en_o,
    output logic            fetch_done_o,
    output logic            fetch_busy_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS      = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("instr_fetch_unit: TIMEOUT_CYCLES must be within 2..65535");
    end

    state_t state;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        drop_pending;

    // The count "reaches" the limit in the cycle whose increment would make it equal
    assign tmo_hit      = ({1'b0, tmo_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES);
    assign fetch_busy_o = (state != IDLE) || drop_pending;

    // Timeout counter runs only while a bus transaction is outstanding; a WAIT
    // timeout leaves one response owed by memory, which is swallowed here
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt      <= '0;
            drop_pending <= 1'b0;
        end else begin
            tmo_cnt <= (state == REQ || state == WAIT) ? tmo_cnt + 16'd1 : '0;
            if (state == WAIT && !imem_rvalid_i && tmo_hit)
                drop_pending <= 1'b1;
            else if (drop_pending && imem_rvalid_i)
                drop_pending <= 1'b0;
        end
    end
`else
    assign fetch_busy_o = (state != IDLE);
`endif

    // Fetch FSM; all bus and IR outputs are registered and set on state entry
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= '0;
            ir_data_o     <= '0;
            ir_wr_en_o    <= 1'b0;
            fetch_done_o  <= 1'b0;
            fault_o       <= 1'b0;
            fault_cause_o <= CAUSE_NONE;
        end else begin
            ir_wr_en_o   <= 1'b0;
            fetch_done_o <= 1'b0;
            fault_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start_i && !fetch_busy_o) begin
                        if (pc_i[1:0] != 2'b00) begin
                            state         <= FAULT;
                            fault_o       <= 1'b1;
                            fetch_done_o  <= 1'b1;
                            fault_cause_o <= CAUSE_MISALIGN;
                        end else begin
                            state         <= REQ;
                            imem_req_o    <= 1'b1;
                            imem_addr_o   <= pc_i;
                            fault_cause_o <= CAUSE_NONE;
                        end
                    end
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        state      <= WAIT;
                        imem_req_o <= 1'b0;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state         <= FAULT;
                        imem_req_o    <= 1'b0;
                        fault_o       <= 1'b1;
                        fetch_done_o  <= 1'b1;
                        fault_cause_o <= CAUSE_TIMEOUT;
                    end
`endif
                end
                WAIT: begin
                    if (imem_rvalid_i && !imem_err_i) begin
                        state        <= DONE;
                        ir_data_o    <= imem_rdata_i;
                        ir_wr_en_o   <= 1'b1;
                        fetch_done_o <= 1'b1;
                    end else if (imem_rvalid_i) begin
                        state         <= FAULT;
                        fault_o       <= 1'b1;
                        fetch_done_o  <= 1'b1;
                        fault_cause_o <= CAUSE_BUS;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state         <= FAULT;
                        fault_o       <= 1'b1;
                        fetch_done_o  <= 1'b1;
                        fault_cause_o <= CAUSE_TIMEOUT;
                    end
`endif
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven fetch vectors with a completion scoreboard,
// plus hand-written reset-mid-fetch and timeout sequences.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        int          gd;
        int          rd;
        logic        err;
        logic [31:0] rdata;
        logic        wr;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        flt;
        logic [1:0]  cause;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 0, rstn = 0, fetch_start = 0, gnt = 0, rvalid = 0, err = 0;
    logic [31:0] pc = 0, rdata = 0;
    logic        req, wr, done, busy, flt;
    logic [31:0] addr, ir;
    logic [1:0]  cause;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    exp_t        sb[$];
    exp_t        e;
    vec_t        vecs[7];
    logic [1:0]  last_cause = 0;
    logic [31:0] last_data = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rstn_i(rstn), .fetch_start_i(fetch_start), .pc_i(pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(err),
        .ir_data_o(ir), .ir_wr_en_o(wr), .fetch_done_o(done),
        .fetch_busy_o(busy), .fault_o(flt), .fault_cause_o(cause)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            chk("wr_only_with_done", {31'b0, wr & ~done}, 0);
            chk("fault_only_with_done", {31'b0, flt & ~done}, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("ir_wr_en", {31'b0, wr}, {31'b0, e.wr});
                    chk("fault", {31'b0, flt}, {31'b0, e.flt});
                    chk("fault_cause", {30'b0, cause}, {30'b0, e.cause});
                    chk("ir_data", ir, e.data);
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) chk("done_timeout", 0, 1);
    endtask

    task automatic start_fetch(input logic [31:0] p, input exp_t x);
        @(negedge clk);
        chk("cause_sticky", {30'b0, cause}, {30'b0, last_cause});
        chk("ir_data_hold", ir, last_data);
        x.due = cyc + x.due;
        sb.push_back(x);
        fetch_start = 1;
        pc = p;
        @(negedge clk);
        fetch_start = 0;
        pc = 32'hFFFF_FFF0;
    endtask

    task automatic run_fetch(input vec_t v);
        exp_t x;
        x.wr = v.wr; x.flt = v.flt; x.cause = v.cause; x.data = v.data;
        x.due = (v.pc[1:0] != 0) ? 1 : 3 + v.gd + v.rd - 1;
        start_fetch(v.pc, x);
        if (v.pc[1:0] != 0) begin
            chk("misaligned_no_req", {31'b0, req}, 0);
        end else begin
            for (int i = 0; i < v.gd; i++) begin
                chk("req_stall", {31'b0, req}, 1);
                chk("addr_stable", addr, v.pc);
                fetch_start = 1;
                pc = 32'h0000_0042;
                @(negedge clk);
                fetch_start = 0;
            end
            chk("req", {31'b0, req}, 1);
            chk("addr", addr, v.pc);
            gnt = 1;
            @(negedge clk);
            gnt = 0;
            chk("req_drop", {31'b0, req}, 0);
            repeat (v.rd - 1) @(negedge clk);
            rvalid = 1; err = v.err; rdata = v.rdata;
            @(negedge clk);
            rvalid = 0; err = 0; rdata = 0;
        end
        wait_done();
        last_cause = v.cause;
        last_data = v.data;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic timeout_wait();
        exp_t x;
        x.wr = 0; x.flt = 1; x.cause = 2'b11; x.data = last_data; x.due = 9;
        start_fetch(32'h0000_0400, x);
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        wait_done();
        chk("tmo_busy_in_fault", {31'b0, busy}, 1);
        @(negedge clk);
        chk("tmo_busy_drop_pending", {31'b0, busy}, 1);
        fetch_start = 1;
        pc = 32'h0000_0500;
        @(negedge clk);
        fetch_start = 0;
        chk("tmo_start_ignored", {31'b0, req}, 0);
        chk("tmo_busy_still", {31'b0, busy}, 1);
        rvalid = 1; rdata = 32'h1111_1111;
        @(negedge clk);
        rvalid = 0; rdata = 0;
        chk("tmo_busy_released", {31'b0, busy}, 0);
        chk("tmo_ir_unchanged", ir, last_data);
        last_cause = 2'b11;
    endtask

    task automatic timeout_req();
        exp_t x;
        x.wr = 0; x.flt = 1; x.cause = 2'b11; x.data = last_data; x.due = 9;
        start_fetch(32'h0000_0404, x);
        wait_done();
        chk("tmo_req_dropped", {31'b0, req}, 0);
        @(negedge clk);
        chk("tmo_req_no_drop_pending", {31'b0, busy}, 0);
        last_cause = 2'b11;
    endtask
`endif

    task automatic reset_mid_fetch();
        @(negedge clk);
        fetch_start = 1;
        pc = 32'h0000_0300;
        @(negedge clk);
        fetch_start = 0;
        gnt = 1;
        @(negedge clk);
        gnt = 0;
        rstn = 0;
        #1;
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ir_data", ir, 0);
        chk("rst_wr", {31'b0, wr}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_fault", {31'b0, flt}, 0);
        chk("rst_cause", {30'b0, cause}, 0);
        @(negedge clk);
        rstn = 1;
        last_cause = 0;
        last_data = 0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0040, 0, 1, 1'b0, 32'h0050_0093, 1'b1, 1'b0, 2'd0, 32'h0050_0093};
        vecs[1] = '{32'h0000_0100, 3, 4, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 2'd0, 32'h1234_5678};
        vecs[2] = '{32'h0000_0042, 0, 1, 1'b0, 32'h0,         1'b0, 1'b1, 2'd1, 32'h1234_5678};
        vecs[3] = '{32'h0000_0200, 1, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 32'h1234_5678};
        vecs[4] = '{32'h0000_0204, 0, 1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 2'd0, 32'hCAFE_F00D};
        vecs[5] = '{32'h0000_0003, 0, 1, 1'b0, 32'h0,         1'b0, 1'b1, 2'd1, 32'hCAFE_F00D};
        vecs[6] = '{32'h0000_0208, 2, 1, 1'b0, 32'h0000_0013, 1'b1, 1'b0, 2'd0, 32'h0000_0013};
        repeat (3) @(negedge clk);
        chk("reset_req", {31'b0, req}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_addr", addr, 0);
        chk("reset_ir", ir, 0);
        rstn = 1;
        foreach (vecs[i]) run_fetch(vecs[i]);
        reset_mid_fetch();
        run_fetch('{32'h0000_0044, 1, 2, 1'b0, 32'h0010_0113, 1'b1, 1'b0, 2'd0, 32'h0010_0113});
`ifdef FETCH_TIMEOUT_EN
        timeout_wait();
        timeout_req();
`else
        run_fetch('{32'h0000_0048, 30, 25, 1'b0, 32'h0020_0193, 1'b1, 1'b0, 2'd0, 32'h0020_0193});
`endif
        run_fetch(vecs[0]);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the multicycle core. On a one-cycle start from the control FSM it issues a single word read on the instruction memory request/grant/valid bus. It buffers the returned word and presents it to the instruction register together with a one-cycle write-enable pulse. Misaligned PCs, bus errors and (optionally) hung transactions are reported as fetch faults instead of writing the instruction register.

## Interface
Parameters:
- XLEN, from riscv_pkg (32): data and address width.
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before a timeout fault. Legal range is 2 to 65535.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- fetch_start_i  in  1  start pulse from the control FSM. Accepted only when fetch_busy_o=0.
- pc_i  in  XLEN  fetch address. Sampled in the start cycle.
- imem_req_o  out  1  memory request.
- imem_addr_o  out  XLEN  request address. Held stable while imem_req_o=1.
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  response valid. Arrives at the earliest one cycle after gnt.
- imem_rdata_i  in  XLEN  response word.
- imem_err_i  in  1  response error. Qualified by imem_rvalid_i.
- ir_data_o  out  XLEN  buffered instruction. Drives the instruction register data input.
- ir_wr_en_o  out  1  one-cycle instruction register write enable.
- fetch_done_o  out  1  one-cycle pulse: fetch ended, successfully or with a fault.
- fetch_busy_o  out  1  a fetch is in progress or a drop is pending.
- fault_o  out  1  one-cycle fault pulse. Coincides with fetch_done_o.
- fault_cause_o  out  2  fault cause: 00 none, 01 misaligned, 10 bus error, 11 timeout. Sticky until the next accepted start.

## Operation
- Every output resets to 0, including ir_data_o and imem_addr_o.
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE, fetch_start_i=1, busy=0:
  - fault_cause_o clears to 00.
  - If pc_i[1:0]!=0: go to FAULT with cause 01. No memory request is issued.
  - Otherwise: latch pc_i into imem_addr_o and go to REQ.
- REQ: imem_req_o=1.
  - On imem_gnt_i: go to WAIT. imem_req_o drops in the next cycle.
- WAIT: imem_req_o=0.
  - On imem_rvalid_i with imem_err_i=0: latch imem_rdata_i into ir_data_o and go to DONE.
  - On imem_rvalid_i with imem_err_i=1: go to FAULT with cause 10. ir_data_o is unchanged.
- DONE: ir_wr_en_o=1 and fetch_done_o=1 for one cycle, then go to IDLE.
- FAULT: fault_o=1 and fetch_done_o=1 for one cycle, then go to IDLE. ir_wr_en_o stays 0.
- fetch_busy_o=1 in REQ, WAIT, DONE and FAULT, and whenever drop_pending=1.
- fetch_start_i with busy=1 is ignored. It is not queued.
- imem_rvalid_i outside WAIT is ignored, unless it is consumed by drop_pending.
- ir_data_o holds its value between fetches.

## Timing
- Zero-wait memory (gnt in the REQ cycle, rvalid in the next cycle):
  - start at cycle 0, req at cycle 1, rvalid at cycle 2, ir_wr_en_o and fetch_done_o at cycle 3.
  - The start-to-write latency is 3 cycles plus the memory stall cycles.
- Misaligned PC: fault_o is asserted in cycle 1.
- ir_data_o is valid in the same cycle as ir_wr_en_o and in every cycle after it.
- Earliest back-to-back start: the cycle after fetch_done_o.
- Asynchronous reset mid-transaction: return to IDLE immediately, all outputs 0, drop_pending cleared. A response still owed by memory is the system's problem, because memory is reset with the core.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering REQ and increments every cycle in REQ and WAIT.
  - When the count reaches TIMEOUT_CYCLES: go to FAULT with cause 11 and drop imem_req_o.
  - A timeout in WAIT sets drop_pending. The next imem_rvalid_i is discarded and then drop_pending clears. busy stays 1 until then.
  - A timeout in REQ sets no drop_pending, because no grant was given.
- FETCH_TIMEOUT_EN undefined:
  - No counter and no drop_pending logic.
  - The unit waits in REQ or WAIT indefinitely.
  - Cause 11 is never produced.

## Test plan
- Zero-wait fetch:
  - Stimulus: pc_i=0x0000_0040, rdata=0x0050_0093.
  - Required: req and addr 0x40 in cycle 1; ir_wr_en_o=1 and ir_data_o=0x0050_0093 in cycle 3; fault_o=0.
- Stalled memory:
  - Stimulus: gnt 3 cycles late, rvalid 4 cycles after gnt.
  - Required: addr stable throughout REQ; exactly one ir_wr_en_o pulse; start ignored while busy.
- Misaligned PC:
  - Stimulus: pc_i=0x0000_0042.
  - Required: imem_req_o never asserted; fault_o in cycle 1; fault_cause_o=01 held until the next start.
- Bus error:
  - Stimulus: rvalid with err=1, rdata=0xDEAD_BEEF.
  - Required: fault_cause_o=10; ir_wr_en_o=0; ir_data_o keeps the previous value.
- Timeout, FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=8:
  - Stimulus: gnt given, no rvalid.
  - Required: fault cause 11 at count 8; busy stays 1; a late rvalid is discarded with no ir_wr_en_o; then busy=0.
- Reset mid-fetch:
  - Stimulus: rstn_i low during WAIT.
  - Required: all outputs 0 immediately; a new fetch after reset completes normally.
